message_serializer: RTL
=======================

# message_serializer

Parametrised framed serial transmitter. It latches a MSG_WIDTH-bit message on a rising edge of `send` and shifts it out on the single-wire `data` line as a framed word: start bit, data bits, optional parity bit, stop bit. Each bit is held for CLKS_PER_BIT clock cycles. It is the generalised successor of the lab message-processing block and feeds the board's serial output pin or a downstream receiver in the same design.

## Interface
- MSG_WIDTH, 5: number of message bits per frame, ≥1.
- CLKS_PER_BIT, 4: clock cycles each bit is held on `data`, ≥1.
- PARITY_EN, 1: 1 inserts a parity bit after the data bits; 0 omits it.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN=0.
- MSB_FIRST, 1: 1 transmits message[MSG_WIDTH-1] first; 0 transmits message[0] first.

- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- send  in  1  transmit request; only a 0→1 transition is acted on, and the level may be held.
- message  in  MSG_WIDTH  payload; sampled only in the cycle the start is accepted.
- data  out  1  serial line; idles high.
- busy  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- done  out  1  one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Outputs per state:
  - IDLE: data=1.
  - START: data=0.
  - DATA: data = current shift-register bit.
  - PARITY: data = XOR of the latched message, inverted when PARITY_ODD=1.
  - STOP: data=1.
- Edge detect: `send_q` is a register holding the previous `send`. A start is accepted when `send & ~send_q` is true and the state is IDLE.
- On acceptance:
  - `message` is copied into the shift register and into the parity source.
  - The bit counter clears, the cycle counter clears, and the state goes to START.
- Each non-IDLE state lasts exactly CLKS_PER_BIT cycles, counted by a cycle counter of width max(1,$clog2(CLKS_PER_BIT)).
- DATA runs MSG_WIDTH bit periods. At the end of each period:
  - The shift register shifts (left when MSB_FIRST=1, right otherwise).
  - The bit counter increments.
- Transitions:
  - START→DATA.
  - DATA→PARITY when PARITY_EN=1, otherwise DATA→STOP. This happens after the last data bit period.
  - PARITY→STOP.
  - STOP→IDLE, with `done`=1 in the first IDLE cycle.
- Frame length: (2 + MSG_WIDTH + PARITY_EN) × CLKS_PER_BIT cycles.
- `send` edges while busy are ignored and not queued. A level still high after `done` does not retrigger; a new 0→1 transition is required.
- `message` changes during a frame have no effect on the frame in progress.
- Reset values (applied immediately on rst=0, with no clock needed):
  - data=1, busy=0, done=0.
  - State IDLE, all counters 0, shift register 0.
  - `send_q`=1, so a `send` already high at reset release does not start a frame.
- Reset asserted mid-frame aborts the frame: data returns to 1 at once, `done` is not pulsed, and nothing resumes after release.

## Timing
- Cycle k: `send`=1 is sampled with `send_q`=0.
- Edge k+1: state=START, data=0, busy=1. `message` is sampled at edge k+1.
- Bit i of the frame (0=start) occupies cycles k+1+i·CLKS_PER_BIT through k+(i+1)·CLKS_PER_BIT.
- The last STOP cycle is k+F, where F is the frame length. At edge k+F+1: state=IDLE, busy=0, done=1.
- At edge k+F+2: done=0.
- Back-to-back frames: the earliest accepted re-trigger is a 0→1 edge sampled in cycle k+F+1 (the `done` cycle). That frame starts at k+F+2, giving one idle-high cycle between frames.
- CLKS_PER_BIT=1: each bit lasts one cycle and the counter is permanently 0.
- All outputs are registered; no combinational path from inputs to `data`.

## Test plan
- Defaults, message=10101, `send` high for 5 cycles after reset release:
  - `data` per 4-cycle bit is 0,1,0,1,0,1,1,1 (start, data MSB first, even parity=1, stop).
  - busy high for exactly 32 cycles, then done high for exactly 1 cycle, and only one frame is sent.
- PARITY_EN=0, MSB_FIRST=0, MSG_WIDTH=8, CLKS_PER_BIT=1, message=8'hA5:
  - `data` is 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop).
  - busy high for 10 cycles.
- PARITY_ODD=1, message=00000:
  - parity bit = 1.
  - message=11111 gives parity bit = 0.
- Second `send` 0→1 pulse in the middle of a frame, with `message` changed to 01010:
  - The frame in progress is unchanged and no second frame follows.
  - A pulse issued in the `done` cycle starts the next frame after exactly one idle cycle, carrying the new message.
- Reset:
  - rst low in the middle of the DATA state: data=1 and busy=0 asynchronously (before the next clock edge), no `done` pulse, line stays idle after release.
  - `send` held high through reset release: no frame starts.

Source files
------------

// File: rtl/message_serializer_if.sv
// Bus between a message source and the framed serial transmitter:
// the request/payload going in and the serial line plus status coming out.
interface message_serializer_if #(
    parameter int MSG_WIDTH = 5
);
    logic                 send;
    logic [MSG_WIDTH-1:0] message;
    logic                 data;
    logic                 busy;
    logic                 done;

    modport master (
        output send,
        output message,
        input  data,
        input  busy,
        input  done
    );

    modport slave (
        input  send,
        input  message,
        output data,
        output busy,
        output done
    );
endinterface

// File: rtl/message_serializer.sv
// Framed serial transmitter: on a rising edge of send it latches the message
// and drives start bit, data bits, optional parity bit and stop bit on a
// single idle-high line, each bit held for CLKS_PER_BIT clocks. All outputs
// come straight from flops; they are loaded from the next-state values.
module message_serializer #(
    parameter int MSG_WIDTH    = 5,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int MSB_FIRST    = 1
) (
    input logic                 clk,
    input logic                 rst,
    message_serializer_if.slave bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(MSG_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MSG_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cyc_cnt;
    logic [CNT_W-1:0]     cyc_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_next;
    logic [MSG_WIDTH-1:0] shift_reg;
    logic [MSG_WIDTH-1:0] shift_next;
    logic [MSG_WIDTH-1:0] parity_src;
    logic [MSG_WIDTH-1:0] parity_next;
    logic                 send_q;
    logic                 data_q;
    logic                 data_next;
    logic                 busy_q;
    logic                 busy_next;
    logic                 done_q;
    logic                 done_next;
    logic                 period_end;

    // Line level for a given state; DATA shows the bit at the outgoing end
    // of the shift register, PARITY recomputes from the latched message.
    function automatic logic line_level(input state_t st,
                                        input logic [MSG_WIDTH-1:0] sh,
                                        input logic [MSG_WIDTH-1:0] par);
        logic lvl;
        case (st)
            START:   lvl = 1'b0;
            DATA:    lvl = (MSB_FIRST != 0) ? sh[MSG_WIDTH-1] : sh[0];
            PARITY:  lvl = (^par) ^ (PARITY_ODD != 0);
            default: lvl = 1'b1;
        endcase
        return lvl;
    endfunction

    assign period_end = (cyc_cnt == CNT_LAST);

    // Next-state, counters, shift register and the registered output values
    always_comb begin
        state_next  = state;
        cyc_next    = cyc_cnt;
        bit_next    = bit_cnt;
        shift_next  = shift_reg;
        parity_next = parity_src;
        done_next   = 1'b0;

        case (state)
            IDLE: begin
                // send_q resets high, so a level already high at reset
                // release is not mistaken for a rising edge.
                if (bus.send && !send_q) begin
                    state_next  = START;
                    shift_next  = bus.message;
                    parity_next = bus.message;
                    cyc_next    = '0;
                    bit_next    = '0;
                end
            end
            START: begin
                if (period_end) begin
                    cyc_next   = '0;
                    state_next = DATA;
                end else begin
                    cyc_next = cyc_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (period_end) begin
                    cyc_next   = '0;
                    shift_next = (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);
                    bit_next   = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_LAST) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end else begin
                    cyc_next = cyc_cnt + CNT_W'(1);
                end
            end
            PARITY: begin
                if (period_end) begin
                    cyc_next   = '0;
                    state_next = STOP;
                end else begin
                    cyc_next = cyc_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (period_end) begin
                    cyc_next   = '0;
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    cyc_next = cyc_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        data_next = line_level(state_next, shift_next, parity_next);
        busy_next = (state_next != IDLE);
    end

    // State, datapath and output registers; reset returns the line to idle at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_src <= '0;
            send_q     <= 1'b1;
            data_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_next;
            cyc_cnt    <= cyc_next;
            bit_cnt    <= bit_next;
            shift_reg  <= shift_next;
            parity_src <= parity_next;
            send_q     <= bus.send;
            data_q     <= data_next;
            busy_q     <= busy_next;
            done_q     <= done_next;
        end
    end

    assign bus.data = data_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
